// File: rtl/spi_m.sv
// SPI master: mode 0, MSB first, active-low chip select, SCK divided from sclk.
// Ports: tx_data/tx_last/tx_valid/tx_ready word source (tx_last closes a burst);
//        rx_data/rx_valid captured word; busy; spi_sck/spi_cs_n/spi_mosi/spi_miso pins.
module spi_m #(
  parameter int WIDTH    = 8,
  parameter int HALF_DIV = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_last,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             spi_sck,
  output logic             spi_cs_n,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int HW = $clog2(HALF_DIV + 1);
  localparam int CMAX =
    (CS_SETUP > CS_HOLD) ?
      ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE) :
      ((CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE);
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [BW-1:0] BIT_END   = BW'(WIDTH);
  localparam logic [HW-1:0] HALF_END  = HW'(HALF_DIV - 1);
  localparam logic [CW-1:0] SETUP_END = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_END  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] IDLE_END  = CW'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    KEEP,
    HOLD,
    GAP
  } state_t;

  state_t           state_q, state_d;
  logic [HW-1:0]    hcnt_q, hcnt_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [CW-1:0]    ccnt_q, ccnt_d;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic             last_q, last_d;

  logic             tx_ready_d;
  logic [WIDTH-1:0] rx_data_d;
  logic             rx_valid_d;
  logic             busy_d;
  logic             sck_d;
  logic             cs_n_d;
  logic             mosi_d;
  logic             accept;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      bcnt_q   <= '0;
      ccnt_q   <= '0;
      tx_sh_q  <= '0;
      rx_sh_q  <= '0;
      last_q   <= 1'b0;
      tx_ready <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      spi_sck  <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_mosi <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      bcnt_q   <= bcnt_d;
      ccnt_q   <= ccnt_d;
      tx_sh_q  <= tx_sh_d;
      rx_sh_q  <= rx_sh_d;
      last_q   <= last_d;
      tx_ready <= tx_ready_d;
      rx_data  <= rx_data_d;
      rx_valid <= rx_valid_d;
      busy     <= busy_d;
      spi_sck  <= sck_d;
      spi_cs_n <= cs_n_d;
      spi_mosi <= mosi_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    bcnt_d     = bcnt_q;
    ccnt_d     = ccnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    last_d     = last_q;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    sck_d      = spi_sck;
    cs_n_d     = spi_cs_n;
    mosi_d     = spi_mosi;
    accept     = tx_valid && tx_ready;

    // tx_ready is only high in IDLE/KEEP, so a word load
    // is common to both entry paths into a transfer.
    if (accept) begin
      tx_sh_d = tx_data;
      last_d  = tx_last;
      rx_sh_d = '0;
      mosi_d  = tx_data[WIDTH-1];
      hcnt_d  = '0;
      bcnt_d  = '0;
      ccnt_d  = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cs_n_d  = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (ccnt_q == SETUP_END) begin
          ccnt_d  = '0;
          hcnt_d  = '0;
          bcnt_d  = '0;
          state_d = XFER;
        end else begin
          ccnt_d = ccnt_q + CW'(1);
        end
      end
      XFER: begin
        if (hcnt_q == HALF_END) begin
          hcnt_d = '0;
          if (!spi_sck) begin
            sck_d   = 1'b1;
            rx_sh_d = {rx_sh_q[WIDTH-2:0], spi_miso};
            bcnt_d  = bcnt_q + BW'(1);
          end else begin
            sck_d = 1'b0;
            // Fall after the final rise closes the word;
            // MOSI is left holding the last bit.
            if (bcnt_q == BIT_END) begin
              rx_data_d  = rx_sh_q;
              rx_valid_d = 1'b1;
              ccnt_d     = '0;
              state_d    = last_q ? HOLD : KEEP;
            end else begin
              mosi_d  = tx_sh_q[WIDTH-2];
              tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
            end
          end
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      KEEP: begin
        if (accept) begin
          state_d = XFER;
        end
      end
      HOLD: begin
        if (ccnt_q == HOLD_END) begin
          ccnt_d  = '0;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          state_d = GAP;
        end else begin
          ccnt_d = ccnt_q + CW'(1);
        end
      end
      GAP: begin
        if (ccnt_q == IDLE_END) begin
          ccnt_d  = '0;
          state_d = IDLE;
        end else begin
          ccnt_d = ccnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    tx_ready_d = (state_d == IDLE) || (state_d == KEEP);
    busy_d     = (state_d != IDLE);
  end

endmodule

// File: tb/tb_spi_m.sv
// Directed bench for spi_m: default 8-bit instance plus a 16-bit, HALF_DIV=1 instance.
// Monitors sample DUT pins on the falling sclk edge; tests compare against hand values.
module tb_spi_m;

  logic        sclk = 1'b0;
  logic        rst_n = 1'b0;

  logic [7:0]  tx_data = '0;
  logic        tx_last = 1'b0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        busy;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;

  logic [15:0] tx_data16 = '0;
  logic        tx_last16 = 1'b0;
  logic        tx_valid16 = 1'b0;
  logic        tx_ready16;
  logic [15:0] rx_data16;
  logic        rx_valid16;
  logic        busy16;
  logic        spi_sck16;
  logic        spi_cs_n16;
  logic        spi_mosi16;
  logic        spi_miso16;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sclk = ~sclk;

  spi_m u8 (
    .sclk     (sclk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .spi_sck  (spi_sck),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  spi_m #(
    .WIDTH    (16),
    .HALF_DIV (1)
  ) u16 (
    .sclk     (sclk),
    .rst_n    (rst_n),
    .tx_data  (tx_data16),
    .tx_last  (tx_last16),
    .tx_valid (tx_valid16),
    .tx_ready (tx_ready16),
    .rx_data  (rx_data16),
    .rx_valid (rx_valid16),
    .busy     (busy16),
    .spi_sck  (spi_sck16),
    .spi_cs_n (spi_cs_n16),
    .spi_mosi (spi_mosi16),
    .spi_miso (spi_miso16)
  );

  // Slave model: presents slv_word MSB first, advancing after each SCK rise.
  logic       miso_mode = 1'b0;
  logic [7:0] slv_word = '0;
  int         rcnt = 0;

  always @(posedge spi_sck or posedge spi_cs_n) begin
    if (spi_cs_n) rcnt <= 0;
    else rcnt <= rcnt + 1;
  end

  assign spi_miso = miso_mode ?
    ((rcnt < 8) ? slv_word[3'(7 - rcnt)] : 1'b0) : spi_mosi;
  assign spi_miso16 = spi_mosi16;

  // Monitor for the 8-bit instance.
  int          rises8 = 0, since8 = 0, per8 = 0;
  int          hi8 = 0, hilast8 = 0;
  int          csrun8 = 0, cslast8 = 0, csr8 = 0, csviol8 = 0;
  int          gap8 = 0, gaplast8 = 0;
  int          rxv8 = 0, rdyb8 = 0;
  logic [31:0] log8 = '0;
  logic [7:0]  rxw [16];
  logic        sck_p8 = 1'b0, cs_p8 = 1'b1;
  wire         rise8 = spi_sck & ~sck_p8;

  always @(negedge sclk) begin
    if (rise8) begin
      rises8 <= rises8 + 1;
      log8   <= {log8[30:0], spi_mosi};
      per8   <= since8 + 1;
      since8 <= 0;
    end else begin
      since8 <= since8 + 1;
    end
    if (spi_sck) hi8 <= hi8 + 1;
    else begin
      if (hi8 > 0) hilast8 <= hi8;
      hi8 <= 0;
    end
    if (!spi_cs_n) csrun8 <= csrun8 + 1;
    else begin
      if (csrun8 > 0) cslast8 <= csrun8;
      csrun8 <= 0;
    end
    if (spi_cs_n && !cs_p8) csr8 <= csr8 + 1;
    if ((spi_cs_n != cs_p8) && (spi_sck || sck_p8)) csviol8 <= csviol8 + 1;
    if (spi_cs_n && !tx_ready) gap8 <= gap8 + 1;
    else begin
      if (gap8 > 0) gaplast8 <= gap8;
      gap8 <= 0;
    end
    if (rx_valid) begin
      rxw[rxv8 % 16] <= rx_data;
      rxv8 <= rxv8 + 1;
    end
    if (busy && tx_ready && !spi_cs_n && spi_sck) rdyb8 <= rdyb8 + 1;
    else if (busy && tx_ready && spi_cs_n) rdyb8 <= rdyb8 + 1;
    sck_p8 <= spi_sck;
    cs_p8  <= spi_cs_n;
  end

  // Monitor for the 16-bit instance.
  int          rises16 = 0, since16 = 0, per16 = 0;
  int          csrun16 = 0, cslast16 = 0, rxv16 = 0;
  logic [31:0] log16 = '0;
  logic        sck_p16 = 1'b0;
  wire         rise16 = spi_sck16 & ~sck_p16;

  always @(negedge sclk) begin
    if (rise16) begin
      rises16 <= rises16 + 1;
      log16   <= {log16[30:0], spi_mosi16};
      per16   <= since16 + 1;
      since16 <= 0;
    end else begin
      since16 <= since16 + 1;
    end
    if (!spi_cs_n16) csrun16 <= csrun16 + 1;
    else begin
      if (csrun16 > 0) cslast16 <= csrun16;
      csrun16 <= 0;
    end
    if (rx_valid16) rxv16 <= rxv16 + 1;
    sck_p16 <= spi_sck16;
  end

  task automatic push8(input logic [7:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    tx_data = d;
    tx_last = l;
    tx_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge sclk);
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL accept8 %h: tx_ready=%b want 1 within 2000 cycles", d, tx_ready);
    end
    @(posedge sclk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait8;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge sclk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL idle8: busy=%b want 0 within 3000 cycles", busy);
    end
    repeat (2) @(posedge sclk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge sclk);
    n_cmp++; if (spi_cs_n !== 1'b1) begin n_bad++; $display("FAIL rst cs_n: got %b want 1", spi_cs_n); end
    n_cmp++; if (spi_sck !== 1'b0) begin n_bad++; $display("FAIL rst sck: got %b want 0", spi_sck); end
    n_cmp++; if (spi_mosi !== 1'b0) begin n_bad++; $display("FAIL rst mosi: got %b want 0", spi_mosi); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL rst tx_ready: got %b want 1", tx_ready); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL rst rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL rst rx_data: got %h want 00", rx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst busy: got %b want 0", busy); end
    n_cmp++; if (spi_cs_n16 !== 1'b1) begin n_bad++; $display("FAIL rst cs_n16: got %b want 1", spi_cs_n16); end
    rst_n = 1'b1;
    repeat (3) @(posedge sclk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post-rst busy: got %b want 0", busy); end
  endtask

  task automatic test_single_loop;
    int r0, v0, cv0;
    r0 = rises8; v0 = rxv8; cv0 = csviol8;
    push8(8'hA5, 1'b1);
    wait8();
    n_cmp++; if (rises8 - r0 !== 8) begin n_bad++; $display("FAIL single rises: got %0d want 8", rises8 - r0); end
    n_cmp++; if (log8[7:0] !== 8'hA5) begin n_bad++; $display("FAIL single mosi bits: got %h want a5", log8[7:0]); end
    n_cmp++; if (rxv8 - v0 !== 1) begin n_bad++; $display("FAIL single rx_valid cycles: got %0d want 1", rxv8 - v0); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL single rx_data: got %h want a5", rx_data); end
    n_cmp++; if (cslast8 !== 36) begin n_bad++; $display("FAIL single cs low: got %0d want 36", cslast8); end
    n_cmp++; if (gaplast8 !== 2) begin n_bad++; $display("FAIL single cs gap: got %0d want 2", gaplast8); end
    n_cmp++; if (csviol8 - cv0 !== 0) begin n_bad++; $display("FAIL single cs with sck high: got %0d want 0", csviol8 - cv0); end
  endtask

  task automatic test_slave_word;
    int v0;
    v0 = rxv8;
    miso_mode = 1'b1;
    slv_word = 8'h3C;
    push8(8'hFF, 1'b1);
    wait8();
    miso_mode = 1'b0;
    n_cmp++; if (rx_data !== 8'h3C) begin n_bad++; $display("FAIL slave rx_data: got %h want 3c", rx_data); end
    n_cmp++; if (log8[7:0] !== 8'hFF) begin n_bad++; $display("FAIL slave mosi bits: got %h want ff", log8[7:0]); end
    n_cmp++; if (per8 !== 4) begin n_bad++; $display("FAIL slave sck period: got %0d want 4", per8); end
    n_cmp++; if (hilast8 !== 2) begin n_bad++; $display("FAIL slave sck high: got %0d want 2", hilast8); end
    n_cmp++; if (rxv8 - v0 !== 1) begin n_bad++; $display("FAIL slave rx_valid cycles: got %0d want 1", rxv8 - v0); end
  endtask

  task automatic test_burst;
    int r0, v0, c0;
    r0 = rises8; v0 = rxv8; c0 = csr8;
    push8(8'h01, 1'b0);
    push8(8'h80, 1'b0);
    push8(8'h7E, 1'b1);
    wait8();
    n_cmp++; if (rises8 - r0 !== 24) begin n_bad++; $display("FAIL burst rises: got %0d want 24", rises8 - r0); end
    n_cmp++; if (rxv8 - v0 !== 3) begin n_bad++; $display("FAIL burst rx_valid cycles: got %0d want 3", rxv8 - v0); end
    n_cmp++; if (rxw[(v0 + 0) % 16] !== 8'h01) begin n_bad++; $display("FAIL burst rx0: got %h want 01", rxw[(v0 + 0) % 16]); end
    n_cmp++; if (rxw[(v0 + 1) % 16] !== 8'h80) begin n_bad++; $display("FAIL burst rx1: got %h want 80", rxw[(v0 + 1) % 16]); end
    n_cmp++; if (rxw[(v0 + 2) % 16] !== 8'h7E) begin n_bad++; $display("FAIL burst rx2: got %h want 7e", rxw[(v0 + 2) % 16]); end
    n_cmp++; if (csr8 - c0 !== 1) begin n_bad++; $display("FAIL burst cs releases: got %0d want 1", csr8 - c0); end
    n_cmp++; if (cslast8 !== 102) begin n_bad++; $display("FAIL burst cs low: got %0d want 102", cslast8); end
    n_cmp++; if (log8[23:0] !== 24'h01807E) begin n_bad++; $display("FAIL burst mosi bits: got %h want 01807e", log8[23:0]); end
  endtask

  task automatic test_valid_held;
    int v0, c0, b0;
    v0 = rxv8; c0 = csr8; b0 = rdyb8;
    push8(8'h11, 1'b1);
    push8(8'h55, 1'b1);
    n_cmp++; if (gaplast8 !== 2) begin n_bad++; $display("FAIL held gap before 55: got %0d want 2", gaplast8); end
    wait8();
    n_cmp++; if (rdyb8 - b0 !== 0) begin n_bad++; $display("FAIL held ready while busy: got %0d want 0", rdyb8 - b0); end
    n_cmp++; if (rxv8 - v0 !== 2) begin n_bad++; $display("FAIL held rx_valid cycles: got %0d want 2", rxv8 - v0); end
    n_cmp++; if (rxw[(v0 + 1) % 16] !== 8'h55) begin n_bad++; $display("FAIL held rx 55: got %h want 55", rxw[(v0 + 1) % 16]); end
    n_cmp++; if (csr8 - c0 !== 2) begin n_bad++; $display("FAIL held cs releases: got %0d want 2", csr8 - c0); end
    n_cmp++; if (log8[15:0] !== 16'h1155) begin n_bad++; $display("FAIL held mosi bits: got %h want 1155", log8[15:0]); end
  endtask

  task automatic test_reset_mid;
    int r0, v0;
    bit hit;
    r0 = rises8; v0 = rxv8; hit = 1'b0;
    push8(8'h96, 1'b1);
    for (int i = 0; i < 500; i++) begin
      @(negedge sclk);
      #1;
      if (rises8 - r0 >= 3) begin
        hit = 1'b1;
        break;
      end
    end
    n_cmp++; if (!hit) begin n_bad++; $display("FAIL mid third rise: rises=%0d want 3", rises8 - r0); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (spi_cs_n !== 1'b1) begin n_bad++; $display("FAIL mid cs_n: got %b want 1", spi_cs_n); end
    n_cmp++; if (spi_sck !== 1'b0) begin n_bad++; $display("FAIL mid sck: got %b want 0", spi_sck); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL mid rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid busy: got %b want 0", busy); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL mid tx_ready: got %b want 1", tx_ready); end
    n_cmp++; if (spi_mosi !== 1'b0) begin n_bad++; $display("FAIL mid mosi: got %b want 0", spi_mosi); end
    @(posedge sclk);
    @(negedge sclk);
    rst_n = 1'b1;
    repeat (40) @(posedge sclk);
    #1;
    n_cmp++; if (rxv8 - v0 !== 0) begin n_bad++; $display("FAIL mid rx_valid after reset: got %0d want 0", rxv8 - v0); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL mid rx_data: got %h want 00", rx_data); end
    v0 = rxv8;
    push8(8'h5A, 1'b1);
    wait8();
    n_cmp++; if (rx_data !== 8'h5A) begin n_bad++; $display("FAIL mid recover rx_data: got %h want 5a", rx_data); end
    n_cmp++; if (rxv8 - v0 !== 1) begin n_bad++; $display("FAIL mid recover rx_valid: got %0d want 1", rxv8 - v0); end
  endtask

  task automatic test_wide;
    int r0, v0;
    bit ok;
    r0 = rises16; v0 = rxv16; ok = 1'b0;
    tx_data16 = 16'hBEEF;
    tx_last16 = 1'b1;
    tx_valid16 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge sclk);
      if (tx_ready16) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge sclk);
    #1;
    tx_valid16 = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wide accept: tx_ready16=%b want 1", tx_ready16); end
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge sclk);
      if (!busy16) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(posedge sclk);
    #1;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wide idle: busy16=%b want 0", busy16); end
    n_cmp++; if (rx_data16 !== 16'hBEEF) begin n_bad++; $display("FAIL wide rx_data: got %h want beef", rx_data16); end
    n_cmp++; if (rises16 - r0 !== 16) begin n_bad++; $display("FAIL wide rises: got %0d want 16", rises16 - r0); end
    n_cmp++; if (per16 !== 2) begin n_bad++; $display("FAIL wide sck period: got %0d want 2", per16); end
    n_cmp++; if (rxv16 - v0 !== 1) begin n_bad++; $display("FAIL wide rx_valid cycles: got %0d want 1", rxv16 - v0); end
    n_cmp++; if (cslast16 !== 36) begin n_bad++; $display("FAIL wide cs low: got %0d want 36", cslast16); end
    n_cmp++; if (log16[15:0] !== 16'hBEEF) begin n_bad++; $display("FAIL wide mosi bits: got %h want beef", log16[15:0]); end
  endtask

  initial begin
    test_reset();
    test_single_loop();
    test_slave_word();
    test_burst();
    test_valid_held();
    test_reset_mid();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
